fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage for the 16-bit single-issue core.
- Holds the PC and drives a request/valid handshake to instruction memory.
- Presents the fetched word to the decoder.
- Computes the next PC from the taken/not-taken result of the branch stage, plus the decoder's jump, halt and reset commands.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_next_pc_calc.sv | 43 ++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_unit_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT     = 16;
    localparam int unsigned BR_OFF_WIDTH_DEFAULT = 6;
    localparam int unsigned INSTR_WIDTH          = 16;
    localparam int unsigned IMM_WIDTH            = 12;
    localparam int unsigned CNT_WIDTH            = 16;
    localparam logic [15:0] RESET_PC_DEFAULT     = 16'h0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_EXEC  = 2'd2;
    localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Priority selection of the retiring instruction's successor PC.
module next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned          BR_OFF_WIDTH = BR_OFF_WIDTH_DEFAULT
) (
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic [IMM_WIDTH-1:0] immediate_i,
    input  logic                 rst_cmd_i,
    input  logic                 halt_cmd_i,
    input  logic                 jump_i,
    input  logic                 branch_taken_i,
    output logic [PC_WIDTH-1:0]  next_pc_c,
    output logic                 halt_c
);

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] br_off;
    logic [PC_WIDTH-1:0] jump_target;

    // Branch offsets are relative to PC+1; all sums wrap modulo 2^PC_WIDTH.
    always_comb begin
        pc_inc      = pc_i + PC_WIDTH'(1);
        br_off      = {{(PC_WIDTH-BR_OFF_WIDTH){immediate_i[BR_OFF_WIDTH-1]}},
                       immediate_i[BR_OFF_WIDTH-1:0]};
        jump_target = {pc_i[PC_WIDTH-1:IMM_WIDTH], immediate_i};
        next_pc_c   = pc_inc;
        halt_c      = 1'b0;
        if (rst_cmd_i) begin
            next_pc_c = RESET_PC;
        end else if (halt_cmd_i) begin
            next_pc_c = pc_i;
            halt_c    = 1'b1;
        end else if (jump_i) begin
            next_pc_c = jump_target;
        end else if (branch_taken_i) begin
            next_pc_c = pc_inc + br_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch FSM for the 16-bit core.
// Optional retired-instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned          BR_OFF_WIDTH = BR_OFF_WIDTH_DEFAULT
) (
    input  logic                   clk_pi,
    input  logic                   reset_n_pi,
    output logic                   imem_req_po,
    output logic [PC_WIDTH-1:0]    imem_addr_po,
    input  logic                   imem_ready_pi,
    input  logic                   imem_valid_pi,
    input  logic [INSTR_WIDTH-1:0] imem_data_pi,
    output logic [INSTR_WIDTH-1:0] instruction_po,
    output logic                   instr_valid_po,
    input  logic                   stall_pi,
    input  logic                   is_branch_taken_pi,
    input  logic                   jump_pi,
    input  logic                   halt_cmd_pi,
    input  logic                   rst_cmd_pi,
    input  logic [IMM_WIDTH-1:0]   immediate_pi,
    output logic [PC_WIDTH-1:0]    pc_po,
    output logic                   halted_po
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]   retired_count_po
`endif
);

    fetch_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   req_q, req_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   go_halt;
    logic                   retire;

    next_pc_calc #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_PC     (RESET_PC),
        .BR_OFF_WIDTH (BR_OFF_WIDTH)
    ) u_next_pc (
        .pc_i           (pc_q),
        .immediate_i    (immediate_pi),
        .rst_cmd_i      (rst_cmd_pi),
        .halt_cmd_i     (halt_cmd_pi),
        .jump_i         (jump_pi),
        .branch_taken_i (is_branch_taken_pi),
        .next_pc_c      (next_pc),
        .halt_c         (go_halt)
    );

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Next state; strobes are registered decodes of the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // The request is only real once it has been presented.
                if (req_q && imem_ready_pi) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_valid_pi) begin
                    instr_d = imem_data_pi;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall_pi) begin
                    retire  = 1'b1;
                    pc_d    = next_pc;
                    state_d = go_halt ? ST_HALT : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        req_d    = (state_d == ST_FETCH);
        valid_d  = (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Saturating count of retirements; a soft reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            if (rst_cmd_pi) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign retired_count_po = cnt_q;
`endif

    assign imem_req_po    = req_q;
    assign imem_addr_po   = pc_q;
    assign pc_po          = pc_q;
    assign instruction_po = instr_q;
    assign instr_valid_po = valid_q;
    assign halted_po      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-level reference model, directed and random stimulus.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_po;
    logic [15:0] imem_addr_po;
    logic        ready;
    logic        valid;
    logic [15:0] data;
    logic [15:0] instruction_po;
    logic        instr_valid_po;
    logic        stall;
    logic        br;
    logic        jmp;
    logic        hlt;
    logic        rcmd;
    logic [11:0] imm;
    logic [15:0] pc_po;
    logic        halted_po;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] retired_count_po;
`endif

    fetch_unit dut (
        .clk_pi             (clk),
        .reset_n_pi         (rst_n),
        .imem_req_po        (imem_req_po),
        .imem_addr_po       (imem_addr_po),
        .imem_ready_pi      (ready),
        .imem_valid_pi      (valid),
        .imem_data_pi       (data),
        .instruction_po     (instruction_po),
        .instr_valid_po     (instr_valid_po),
        .stall_pi           (stall),
        .is_branch_taken_pi (br),
        .jump_pi            (jmp),
        .halt_cmd_pi        (hlt),
        .rst_cmd_pi         (rcmd),
        .immediate_pi       (imm),
        .pc_po              (pc_po),
        .halted_po          (halted_po)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_count_po   (retired_count_po)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase of the instruction life cycle plus architectural values.
    localparam int P_FETCH = 0;
    localparam int P_WAIT  = 1;
    localparam int P_EXEC  = 2;
    localparam int P_HALT  = 3;

    int m_ph;
    int m_pc;
    int m_instr;
    int m_req;
    int m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = P_FETCH; m_pc = 0; m_instr = 0; m_req = 0; m_cnt = 0;
    endtask

    function automatic int br_offset(input logic [11:0] i);
        int o;
        o = int'(i[5:0]);
        if (o >= 32) o = o - 64;
        return o;
    endfunction

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_step();
        if (!rst_n) begin
            m_reset();
            return;
        end
        case (m_ph)
            P_FETCH: if (m_req != 0 && ready) m_ph = P_WAIT;
            P_WAIT: if (valid) begin m_ph = P_EXEC; m_instr = int'(data); end
            P_EXEC: if (!stall) begin
                if (m_cnt != 65535) m_cnt++;
                if (rcmd) begin m_pc = 0; m_cnt = 0; m_ph = P_FETCH; end
                else if (hlt) m_ph = P_HALT;
                else begin
                    if (jmp) m_pc = (m_pc & 32'hF000) | int'(imm);
                    else if (br) m_pc = (m_pc + 1 + br_offset(imm)) & 32'hFFFF;
                    else m_pc = (m_pc + 1) & 32'hFFFF;
                    m_ph = P_FETCH;
                end
            end
            default: ;
        endcase
        m_req = (m_ph == P_FETCH) ? 1 : 0;
    endtask

    task automatic compare();
        chk("imem_req", 32'(imem_req_po), 32'(m_req));
        chk("imem_addr", 32'(imem_addr_po), 32'(m_pc));
        chk("pc", 32'(pc_po), 32'(m_pc));
        chk("instruction", 32'(instruction_po), 32'(m_instr));
        chk("instr_valid", 32'(instr_valid_po), 32'(m_ph == P_EXEC));
        chk("halted", 32'(halted_po), 32'(m_ph == P_HALT));
`ifdef FETCH_PERF_CNT_EN
        chk("retired_count", 32'(retired_count_po), 32'(m_cnt));
`endif
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_cmds();
        stall = 0; br = 0; jmp = 0; hlt = 0; rcmd = 0; imm = '0;
    endtask

    task automatic run_to_exec(input logic [15:0] word);
        int n;
        clear_cmds();
        ready = 1; valid = 1; data = word;
        n = 0;
        while (m_ph != P_EXEC && n < 8) begin
            tick();
            n++;
        end
        chk("reach_exec", 32'(m_ph == P_EXEC), 32'd1);
    endtask

    task automatic retire(input logic r, input logic h, input logic j, input logic b,
                          input logic [11:0] im);
        stall = 0; rcmd = r; hlt = h; jmp = j; br = b; imm = im;
        tick();
        clear_cmds();
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    int vcnt;
    int rcnt;
    int hcnt;
    logic [15:0] addrs [$];

    initial begin
        rst_n = 1; ready = 0; valid = 0; data = '0;
        clear_cmds();
        m_reset();
        #1 rst_n = 0;
        @(negedge clk);
        compare();
        chk("rst_pc", 32'(pc_po), 32'h0);
        chk("rst_req", 32'(imem_req_po), 32'd0);
        chk("rst_instr", 32'(instruction_po), 32'h0);
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        chk("req_after_rst", 32'(imem_req_po), 32'd1);

        // Sequential fetch with zero-wait memory.
        ready = 1; valid = 1; data = 16'h0000;
        vcnt = 0;
        addrs.push_back(imem_addr_po);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (instr_valid_po) vcnt++;
            if (imem_req_po) addrs.push_back(imem_addr_po);
        end
        chk("seq_valid_count", 32'(vcnt), 32'd3);
        chk("seq_addr0", 32'(addrs[0]), 32'h0);
        chk("seq_addr1", 32'(addrs[1]), 32'h1);
        chk("seq_addr2", 32'(addrs[2]), 32'h2);

        // Branches taken / not taken.
        run_to_exec(16'h1111); retire(0, 0, 1, 0, 12'h010);
        chk("jump_010", 32'(imem_addr_po), 32'h0010);
        run_to_exec(16'h2222); retire(0, 0, 0, 1, 12'h03E);
        chk("branch_taken", 32'(imem_addr_po), 32'h000F);
        run_to_exec(16'h3333); retire(0, 0, 1, 0, 12'h010);
        run_to_exec(16'h4444); retire(0, 0, 0, 0, 12'h03E);
        chk("branch_not_taken", 32'(imem_addr_po), 32'h0011);

        // Page crossing and jump over branch.
        run_to_exec(16'h5555); retire(0, 0, 1, 0, 12'hFFF);
        run_to_exec(16'h5555); retire(0, 0, 0, 0, 12'h000);
        chk("page_carry", 32'(pc_po), 32'h1000);
        run_to_exec(16'h6666); retire(0, 0, 1, 0, 12'h234);
        chk("jump_1234", 32'(pc_po), 32'h1234);
        run_to_exec(16'h7777); retire(0, 0, 1, 1, 12'hABC);
        chk("jump_beats_branch", 32'(pc_po), 32'h1ABC);

        // Soft reset, negative wrap, self-loop, command priority.
        run_to_exec(16'h8888); retire(1, 0, 1, 0, 12'h123);
        chk("rst_cmd_pc", 32'(pc_po), 32'h0000);
        run_to_exec(16'h9999); retire(0, 0, 0, 1, 12'h03E);
        chk("neg_wrap", 32'(pc_po), 32'hFFFF);
        run_to_exec(16'hAAAA); retire(0, 0, 0, 0, 12'h000);
        chk("pos_wrap", 32'(pc_po), 32'h0000);
        run_to_exec(16'hBBBB); retire(0, 0, 1, 0, 12'h055);
        run_to_exec(16'hCCCC); retire(0, 0, 0, 1, 12'h03F);
        chk("self_loop", 32'(pc_po), 32'h0055);
        run_to_exec(16'hDDDD); retire(1, 1, 1, 1, 12'h321);
        chk("rst_cmd_prio_pc", 32'(pc_po), 32'h0000);
        chk("rst_cmd_refetch", 32'(imem_req_po), 32'd1);
        chk("rst_cmd_not_halted", 32'(halted_po), 32'd0);

        // Stall holds instruction and PC.
        run_to_exec(16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            stall = 1; hlt = 1; rcmd = 1; jmp = 1; imm = 12'hFFF;
            tick();
            chk("stall_instr", 32'(instruction_po), 32'hBEEF);
            chk("stall_pc", 32'(pc_po), 32'h0000);
            chk("stall_valid", 32'(instr_valid_po), 32'd1);
        end
        retire(0, 0, 0, 0, 12'h000);
        chk("stall_release", 32'(pc_po), 32'h0001);

        // Async reset while waiting; a late valid is ignored.
        run_to_exec(16'h1234); retire(0, 0, 1, 0, 12'h077);
        ready = 1; valid = 0;
        for (int i = 0; i < 4 && m_ph != P_WAIT; i++) tick();
        chk("in_wait", 32'(m_ph == P_WAIT), 32'd1);
        #2 rst_n = 0;
        m_reset();
        #1;
        chk("async_rst_pc", 32'(pc_po), 32'h0000);
        chk("async_rst_req", 32'(imem_req_po), 32'd0);
        @(negedge clk);
        compare();
        rst_n = 1; ready = 0; valid = 1; data = 16'hDEAD;
        for (int i = 0; i < 3; i++) tick();
        chk("late_valid_ignored", 32'(instr_valid_po), 32'd0);
        chk("late_valid_req", 32'(imem_req_po), 32'd1);
        chk("late_valid_instr", 32'(instruction_po), 32'h0000);
        run_to_exec(16'h0F0F); retire(0, 0, 0, 0, 12'h000);
        chk("restart_pc", 32'(pc_po), 32'h0001);

        // Halt is sticky until reset_n.
        run_to_exec(16'hF00D); retire(0, 1, 1, 1, 12'h0AA);
        chk("halted", 32'(halted_po), 32'd1);
        rcnt = 0;
        for (int i = 0; i < 20; i++) begin
            ready = 1; valid = 1'($urandom_range(0, 1)); data = 16'($urandom);
            rcmd = 1'($urandom_range(0, 1)); jmp = 1'($urandom_range(0, 1));
            hlt = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1)); imm = 12'($urandom);
            tick();
            if (imem_req_po) rcnt++;
        end
        clear_cmds();
        chk("halt_no_req", 32'(rcnt), 32'd0);
        chk("halt_pc", 32'(pc_po), 32'h0001);
        chk("halt_still", 32'(halted_po), 32'd1);
        rst_n = 0;
        tick();
        chk("halt_rst_pc", 32'(pc_po), 32'h0000);
        chk("halt_rst_halted", 32'(halted_po), 32'd0);
        rst_n = 1;
        tick();

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_to_exec(16'(k));
            if (k == 1) begin
                stall = 1;
                for (int s = 0; s < 3; s++) tick();
                stall = 0;
            end
            retire(0, 0, 0, 0, 12'h000);
        end
        chk("perf_count5", 32'(retired_count_po), 32'd5);
`endif

        // Randomised run against the model.
        do_reset();
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 599) == 0) rst_n = 0;
            else if (hcnt > 15) rst_n = 0;
            ready = ($urandom_range(0, 3) != 0);
            valid = ($urandom_range(0, 2) != 0);
            data  = 16'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            br    = 1'($urandom_range(0, 1));
            jmp   = ($urandom_range(0, 3) == 0);
            hlt   = ($urandom_range(0, 79) == 0);
            rcmd  = ($urandom_range(0, 49) == 0);
            imm   = 12'($urandom);
            tick();
            if (m_ph == P_HALT) hcnt++;
            else hcnt = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
